// File: rtl/prt_dptx_trn_ctl.sv
// DP TX training pattern sequencer: loads a TPS1/TPS2 message into the training
// pattern RAM, waits a settle interval, then switches the lane mux to training.
module prt_dptx_trn_ctl #(
  parameter int unsigned P_SPL     = 2,
  parameter int unsigned P_MSG_IDX = 5,
  parameter int unsigned P_MSG_DAT = 16,
  parameter int unsigned P_MSG_ID  = 0,
  parameter int unsigned P_SETTLE  = 4
) (
  input  logic                 CLK_IN,
  input  logic                 RST_IN,
  input  logic [1:0]           CTL_TPS_IN,
  input  logic                 CTL_STR_IN,
  output logic                 STA_BUSY_OUT,
  output logic                 STA_ACT_OUT,
  output logic                 STA_ERR_OUT,
  input  logic                 MSG_RDY_IN,
  output logic                 MSG_VLD_OUT,
  output logic                 MSG_FIRST_OUT,
  output logic                 MSG_LAST_OUT,
  output logic [P_MSG_IDX-1:0] MSG_IDX_OUT,
  output logic [P_MSG_DAT-1:0] MSG_DAT_OUT,
  output logic                 TRN_SEL_OUT
);

  // Data word count is lcm(pattern length, P_SPL); P_SPL is 2 or 4.
  localparam int unsigned N_TPS1 = P_SPL;
  localparam int unsigned N_TPS2 = (P_SPL == 4) ? 20 : 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DAT,
    ST_SETTLE,
    ST_ACTIVE
  } state_t;

  state_t               state_q, state_d;
  logic                 tps2_q, tps2_d;
  logic [P_MSG_IDX-1:0] idx_q, idx_d;
  logic [3:0]           sym_q, sym_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 act_q, act_d;
  logic                 sel_q, sel_d;
  logic                 err_q, err_d;
  logic                 last_word;
  logic                 sym_wrap;

  function automatic logic [10:0] tps2_sym(input logic [3:0] s);
    case (s)
      4'd0:    tps2_sym = 11'h6BC;
      4'd1:    tps2_sym = 11'h0CB;
      4'd2:    tps2_sym = 11'h7BC;
      4'd3:    tps2_sym = 11'h0CB;
      default: tps2_sym = 11'h04A;
    endcase
  endfunction

  assign last_word = tps2_q ? (idx_q == P_MSG_IDX'(N_TPS2)) : (idx_q == P_MSG_IDX'(N_TPS1));
  assign sym_wrap  = tps2_q ? (sym_q == 4'd9) : 1'b1;

  always_ff @(posedge CLK_IN) begin
    if (!RST_IN) begin
      state_q <= ST_IDLE;
      tps2_q  <= 1'b0;
      idx_q   <= '0;
      sym_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      act_q   <= 1'b0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tps2_q  <= tps2_d;
      idx_q   <= idx_d;
      sym_q   <= sym_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      act_q   <= act_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tps2_d  = tps2_q;
    idx_d   = idx_q;
    sym_d   = sym_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    act_d   = act_q;
    sel_d   = sel_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACTIVE: begin
        if (CTL_STR_IN) begin
          case (CTL_TPS_IN)
            2'd0: begin
              state_d = ST_IDLE;
              sel_d   = 1'b0;
              act_d   = 1'b0;
            end
            2'd1, 2'd2: begin
              // TRN_SEL is left alone so a reload from ACTIVE keeps training selected
              state_d = ST_HDR;
              tps2_d  = CTL_TPS_IN[1];
              idx_d   = '0;
              sym_d   = '0;
              busy_d  = 1'b1;
              act_d   = 1'b0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_HDR: begin
        err_d = CTL_STR_IN;
        if (MSG_RDY_IN) begin
          state_d = ST_DAT;
          idx_d   = P_MSG_IDX'(1);
          sym_d   = '0;
        end
      end
      ST_DAT: begin
        err_d = CTL_STR_IN;
        if (MSG_RDY_IN) begin
          if (last_word) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end else begin
            idx_d = idx_q + P_MSG_IDX'(1);
            sym_d = sym_wrap ? 4'd0 : sym_q + 4'd1;
          end
        end
      end
      ST_SETTLE: begin
        err_d = CTL_STR_IN;
        if (cnt_q == 8'(P_SETTLE - 1)) begin
          state_d = ST_ACTIVE;
          sel_d   = 1'b1;
          act_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    MSG_VLD_OUT   = 1'b0;
    MSG_FIRST_OUT = 1'b0;
    MSG_LAST_OUT  = 1'b0;
    MSG_IDX_OUT   = '0;
    MSG_DAT_OUT   = '0;
    case (state_q)
      ST_HDR: begin
        MSG_VLD_OUT   = 1'b1;
        MSG_FIRST_OUT = 1'b1;
        MSG_DAT_OUT   = P_MSG_DAT'(P_MSG_ID);
      end
      ST_DAT: begin
        MSG_VLD_OUT       = 1'b1;
        MSG_LAST_OUT      = last_word;
        MSG_IDX_OUT       = idx_q;
        MSG_DAT_OUT[10:0] = tps2_q ? tps2_sym(sym_q) : 11'h04A;
      end
      default: ;
    endcase
  end

  assign STA_BUSY_OUT = busy_q;
  assign STA_ACT_OUT  = act_q;
  assign STA_ERR_OUT  = err_q;
  assign TRN_SEL_OUT  = sel_q;

endmodule

// File: tb/tb_prt_dptx_trn_ctl.sv
// Directed bench for prt_dptx_trn_ctl: one instance with P_SPL=2 and one with P_SPL=4.
module tb_prt_dptx_trn_ctl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  tps = 2'd0;
  logic        str2 = 1'b0, str4 = 1'b0;
  logic        rdy = 1'b1;

  logic        busy2, act2, err2, vld2, first2, last2, sel2;
  logic [4:0]  idx2;
  logic [15:0] dat2;
  logic        busy4, act4, err4, vld4, first4, last4, sel4;
  logic [4:0]  idx4;
  logic [15:0] dat4;

  int checks = 0;
  int failures = 0;

  logic [15:0] w_dat [64];
  logic [4:0]  w_idx [64];
  logic        w_first [64];
  logic        w_last [64];
  logic [15:0] tps2_tab [10] = '{16'h6BC, 16'h0CB, 16'h7BC, 16'h0CB, 16'h04A,
                                 16'h04A, 16'h04A, 16'h04A, 16'h04A, 16'h04A};

  always #5 clk = ~clk;

  prt_dptx_trn_ctl #(.P_SPL(2), .P_MSG_IDX(5), .P_MSG_DAT(16), .P_MSG_ID(0), .P_SETTLE(4)) u_dut2 (
    .CLK_IN(clk), .RST_IN(rst_n), .CTL_TPS_IN(tps), .CTL_STR_IN(str2),
    .STA_BUSY_OUT(busy2), .STA_ACT_OUT(act2), .STA_ERR_OUT(err2),
    .MSG_RDY_IN(rdy), .MSG_VLD_OUT(vld2), .MSG_FIRST_OUT(first2), .MSG_LAST_OUT(last2),
    .MSG_IDX_OUT(idx2), .MSG_DAT_OUT(dat2), .TRN_SEL_OUT(sel2)
  );

  prt_dptx_trn_ctl #(.P_SPL(4), .P_MSG_IDX(5), .P_MSG_DAT(16), .P_MSG_ID(0), .P_SETTLE(4)) u_dut4 (
    .CLK_IN(clk), .RST_IN(rst_n), .CTL_TPS_IN(tps), .CTL_STR_IN(str4),
    .STA_BUSY_OUT(busy4), .STA_ACT_OUT(act4), .STA_ERR_OUT(err4),
    .MSG_RDY_IN(rdy), .MSG_VLD_OUT(vld4), .MSG_FIRST_OUT(first4), .MSG_LAST_OUT(last4),
    .MSG_IDX_OUT(idx4), .MSG_DAT_OUT(dat4), .TRN_SEL_OUT(sel4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input bit big, input logic [1:0] code);
    tps = code;
    if (big) str4 = 1'b1; else str2 = 1'b1;
    step();
    str2 = 1'b0;
    str4 = 1'b0;
  endtask

  // Collects accepted words until STA_ACT rises; cyc 0 is the sample just after the start edge.
  task automatic run_msg(input bit big, input int stall_idx, input int stall_len,
                         output int nw, output int act_cyc, output bit held_ok, output bit sel_low);
    int cyc = 0;
    int left = stall_len;
    bit hold_set = 1'b0;
    logic [22:0] hold_w = '0;
    logic v, f, l, a, s;
    logic [4:0] ix;
    logic [15:0] d;
    nw = 0; act_cyc = -1; held_ok = 1'b1; sel_low = 1'b0;
    while (cyc < 200) begin
      v = big ? vld4 : vld2;   f = big ? first4 : first2; l = big ? last4 : last2;
      ix = big ? idx4 : idx2;  d = big ? dat4 : dat2;
      a = big ? act4 : act2;   s = big ? sel4 : sel2;
      if (!s) sel_low = 1'b1;
      if (a) begin
        act_cyc = cyc;
        break;
      end
      rdy = 1'b1;
      if (v && !f && int'(ix) == stall_idx && stall_len > 0) begin
        if (!hold_set) begin
          hold_w = {f, l, ix, d};
          hold_set = 1'b1;
        end else if ({f, l, ix, d} !== hold_w) begin
          held_ok = 1'b0;
        end
        if (left > 0) begin
          rdy = 1'b0;
          left--;
        end
      end
      if (v && rdy && nw < 64) begin
        w_first[nw] = f; w_last[nw] = l; w_idx[nw] = ix; w_dat[nw] = d;
        nw++;
      end
      step();
      cyc++;
    end
    rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({busy2, act2, err2, vld2, first2, last2, idx2, dat2, sel2} !== '0) begin
      failures++;
      $display("FAIL reset_dut2 got=%0h exp=0", {busy2, act2, err2, vld2, first2, last2, idx2, dat2, sel2});
    end
    checks++;
    if ({busy4, act4, err4, vld4, first4, last4, idx4, dat4, sel4} !== '0) begin
      failures++;
      $display("FAIL reset_dut4 got=%0h exp=0", {busy4, act4, err4, vld4, first4, last4, idx4, dat4, sel4});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_tps1();
    int nw, ac; bit held, sl;
    start(1'b0, 2'd1);
    checks++;
    if ({busy2, act2, sel2} !== 3'b100) begin
      failures++;
      $display("FAIL tps1_status got=%b exp=100", {busy2, act2, sel2});
    end
    run_msg(1'b0, -1, 0, nw, ac, held, sl);
    checks++;
    if (nw != 3) begin
      failures++;
      $display("FAIL tps1_count got=%0d exp=3", nw);
    end
    for (int k = 0; k < nw && k < 3; k++) begin
      checks++;
      if ({w_first[k], w_last[k], w_idx[k], w_dat[k]} !== {k == 0, k == 2, 5'(k), (k == 0) ? 16'h0 : 16'h04A}) begin
        failures++;
        $display("FAIL tps1_word%0d got=%0h exp=%0h", k, {w_first[k], w_last[k], w_idx[k], w_dat[k]},
                 {k == 0, k == 2, 5'(k), (k == 0) ? 16'h0 : 16'h04A});
      end
    end
    checks++;
    if (ac != 7) begin
      failures++;
      $display("FAIL tps1_sel_latency got=%0d exp=7", ac);
    end
    checks++;
    if ({busy2, act2, sel2} !== 3'b011) begin
      failures++;
      $display("FAIL tps1_active got=%b exp=011", {busy2, act2, sel2});
    end
  endtask

  task automatic test_tps2_spl4();
    int nw, ac; bit held, sl;
    logic [22:0] exp_w;
    start(1'b1, 2'd2);
    run_msg(1'b1, -1, 0, nw, ac, held, sl);
    checks++;
    if (nw != 21) begin
      failures++;
      $display("FAIL tps2_count got=%0d exp=21", nw);
    end
    for (int k = 0; k < nw && k < 21; k++) begin
      exp_w = {k == 0, k == 20, 5'(k), (k == 0) ? 16'h0 : tps2_tab[(k - 1) % 10]};
      checks++;
      if ({w_first[k], w_last[k], w_idx[k], w_dat[k]} !== exp_w) begin
        failures++;
        $display("FAIL tps2_word%0d got=%0h exp=%0h", k, {w_first[k], w_last[k], w_idx[k], w_dat[k]}, exp_w);
      end
    end
    checks++;
    if (ac != 25 || {busy4, act4, sel4} !== 3'b011) begin
      failures++;
      $display("FAIL tps2_active got=%0d/%b exp=25/011", ac, {busy4, act4, sel4});
    end
  endtask

  task automatic test_stall();
    int nw, ac; bit held, sl;
    logic [22:0] exp_w;
    start(1'b0, 2'd2);
    run_msg(1'b0, 5, 3, nw, ac, held, sl);
    checks++;
    if (nw != 11) begin
      failures++;
      $display("FAIL stall_count got=%0d exp=11", nw);
    end
    for (int k = 0; k < nw && k < 11; k++) begin
      exp_w = {k == 0, k == 10, 5'(k), (k == 0) ? 16'h0 : tps2_tab[k - 1]};
      checks++;
      if ({w_first[k], w_last[k], w_idx[k], w_dat[k]} !== exp_w) begin
        failures++;
        $display("FAIL stall_word%0d got=%0h exp=%0h", k, {w_first[k], w_last[k], w_idx[k], w_dat[k]}, exp_w);
      end
    end
    checks++;
    if (!held) begin
      failures++;
      $display("FAIL stall_hold got=0 exp=1");
    end
    checks++;
    if (ac != 18) begin
      failures++;
      $display("FAIL stall_sel_latency got=%0d exp=18", ac);
    end
  endtask

  task automatic test_reload();
    int nw, ac; bit held, sl;
    bit vld_seen = 1'b0;
    start(1'b0, 2'd1);
    checks++;
    if ({busy2, act2, sel2} !== 3'b101) begin
      failures++;
      $display("FAIL reload1_status got=%b exp=101", {busy2, act2, sel2});
    end
    run_msg(1'b0, -1, 0, nw, ac, held, sl);
    checks++;
    if (nw != 3 || ac != 7 || sl) begin
      failures++;
      $display("FAIL reload1_run got=%0d/%0d/%0d exp=3/7/0", nw, ac, sl);
    end
    start(1'b0, 2'd2);
    checks++;
    if ({busy2, act2, sel2} !== 3'b101) begin
      failures++;
      $display("FAIL reload2_status got=%b exp=101", {busy2, act2, sel2});
    end
    run_msg(1'b0, -1, 0, nw, ac, held, sl);
    checks++;
    if (nw != 11 || ac != 15 || sl) begin
      failures++;
      $display("FAIL reload2_run got=%0d/%0d/%0d exp=11/15/0", nw, ac, sl);
    end
    start(1'b0, 2'd0);
    checks++;
    if ({busy2, act2, sel2, vld2} !== 4'b0000) begin
      failures++;
      $display("FAIL tps0_off got=%b exp=0000", {busy2, act2, sel2, vld2});
    end
    for (int i = 0; i < 4; i++) begin
      if (vld2) vld_seen = 1'b1;
      step();
    end
    checks++;
    if (vld_seen) begin
      failures++;
      $display("FAIL tps0_no_msg got=1 exp=0");
    end
  endtask

  task automatic test_error();
    int nw, ac; bit held, sl;
    logic [22:0] exp_w;
    rdy = 1'b1;
    start(1'b0, 2'd2);
    step();
    step();
    tps = 2'd1;
    str2 = 1'b1;
    step();
    str2 = 1'b0;
    checks++;
    if ({err2, busy2, idx2} !== {2'b11, 5'd3}) begin
      failures++;
      $display("FAIL busy_err_pulse got=%0h exp=%0h", {err2, busy2, idx2}, {2'b11, 5'd3});
    end
    step();
    checks++;
    if ({err2, idx2} !== {1'b0, 5'd4}) begin
      failures++;
      $display("FAIL busy_err_clear got=%0h exp=%0h", {err2, idx2}, {1'b0, 5'd4});
    end
    run_msg(1'b0, -1, 0, nw, ac, held, sl);
    checks++;
    if (nw != 7 || ac != 11) begin
      failures++;
      $display("FAIL busy_err_rest got=%0d/%0d exp=7/11", nw, ac);
    end
    for (int i = 0; i < nw && i < 7; i++) begin
      exp_w = {1'b0, i == 6, 5'(4 + i), tps2_tab[3 + i]};
      checks++;
      if ({w_first[i], w_last[i], w_idx[i], w_dat[i]} !== exp_w) begin
        failures++;
        $display("FAIL busy_err_word%0d got=%0h exp=%0h", 4 + i, {w_first[i], w_last[i], w_idx[i], w_dat[i]}, exp_w);
      end
    end
    start(1'b0, 2'd0);
    start(1'b0, 2'd3);
    checks++;
    if ({err2, busy2, vld2, sel2, act2} !== 5'b10000) begin
      failures++;
      $display("FAIL code3_err got=%b exp=10000", {err2, busy2, vld2, sel2, act2});
    end
    step();
    checks++;
    if ({err2, busy2, vld2} !== 3'b000) begin
      failures++;
      $display("FAIL code3_clear got=%b exp=000", {err2, busy2, vld2});
    end
  endtask

  task automatic test_reset_mid();
    int nw, ac; bit held, sl;
    rdy = 1'b1;
    start(1'b0, 2'd2);
    step();
    step();
    step();
    checks++;
    if (idx2 !== 5'd3) begin
      failures++;
      $display("FAIL rstmid_pre got=%0d exp=3", idx2);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if ({busy2, act2, err2, vld2, first2, last2, idx2, dat2, sel2} !== '0) begin
      failures++;
      $display("FAIL rstmid_zero got=%0h exp=0", {busy2, act2, err2, vld2, first2, last2, idx2, dat2, sel2});
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({busy2, vld2} !== 2'b00) begin
      failures++;
      $display("FAIL rstmid_idle got=%b exp=00", {busy2, vld2});
    end
    start(1'b0, 2'd1);
    run_msg(1'b0, -1, 0, nw, ac, held, sl);
    checks++;
    if (nw != 3 || ac != 7) begin
      failures++;
      $display("FAIL rstmid_restart got=%0d/%0d exp=3/7", nw, ac);
    end
    for (int k = 0; k < nw && k < 3; k++) begin
      checks++;
      if ({w_first[k], w_last[k], w_idx[k], w_dat[k]} !== {k == 0, k == 2, 5'(k), (k == 0) ? 16'h0 : 16'h04A}) begin
        failures++;
        $display("FAIL rstmid_word%0d got=%0h exp=%0h", k, {w_first[k], w_last[k], w_idx[k], w_dat[k]},
                 {k == 0, k == 2, 5'(k), (k == 0) ? 16'h0 : 16'h04A});
      end
    end
  endtask

  initial begin
    test_reset();
    test_tps1();
    test_tps2_spl4();
    test_stall();
    test_reload();
    test_error();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
